// File: rtl/test_status_reporter_if.sv
// Register-file write-back snoop bus.
// Carries the core's write-back port towards observers such as the test
// status reporter.
//   reg_wr_en    write enable from the write-back stage
//   reg_wr_addr  destination register index (x0..x31)
//   reg_wr_data  value being written
// modport master: the core (drives the bus); modport slave: the observer.
interface test_status_reporter_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 reg_wr_en;
    logic [4:0]           reg_wr_addr;
    logic [CPU_WIDTH-1:0] reg_wr_data;

    modport master (
        output reg_wr_en,
        output reg_wr_addr,
        output reg_wr_data
    );

    modport slave (
        input reg_wr_en,
        input reg_wr_addr,
        input reg_wr_data
    );
endinterface

// File: rtl/test_status_reporter.sv
// On-chip pass/fail reporter for riscv-tests.
// Snoops the register-file write port. A write of 1 to DONE_REG ends the test:
// the verdict comes from the PASS_REG shadow and the failing test number from
// the TNUM_REG shadow. The verdict is shown on two LEDs and sent as an ASCII
// 8N1 UART message ("PASS\r\n" or "FAIL hh\r\n").
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wb           write-back snoop bus (slave modport)
//   uart_tx      serial output, idle high, 8N1, LSB first
//   led          led[0] = test finished, led[1] = test passed
//   report_busy  high from SETTLE until the last stop bit ends
//   report_done  high once the whole message has been sent
module test_status_reporter #(
    parameter int CPU_WIDTH = 32,
    parameter int CLK_DIV   = 434,
    parameter int DONE_REG  = 26,
    parameter int PASS_REG  = 27,
    parameter int TNUM_REG  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    test_status_reporter_if.slave  wb,
    output logic                   uart_tx,
    output logic [1:0]             led,
    output logic                   report_busy,
    output logic                   report_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        DATA,
        STOP,
        HALT
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [4:0]  DONE_ADDR = 5'(DONE_REG);
    localparam logic [4:0]  PASS_ADDR = 5'(PASS_REG);
    localparam logic [4:0]  TNUM_ADDR = 5'(TNUM_REG);

    state_t               state, n_state;
    logic [CPU_WIDTH-1:0] pass_sh, tnum_sh;
    logic                 verdict, n_verdict;
    logic [3:0]           char_idx, n_char_idx;
    logic [2:0]           bit_idx, n_bit_idx;
    logic [15:0]          cnt, n_cnt;
    logic                 n_tx;
    logic [1:0]           n_led;
    logic [7:0]           cur_char;
    logic [3:0]           last_idx;
    logic                 wr_live, done_hit, shadow_open;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    assign wr_live     = wb.reg_wr_en && (wb.reg_wr_addr != 5'd0);
    assign done_hit    = wr_live && (wb.reg_wr_addr == DONE_ADDR) &&
                         (wb.reg_wr_data == CPU_WIDTH'(1));
    assign shadow_open = (state == IDLE) || (state == SETTLE);

    assign report_busy = (state == SETTLE) || (state == START) ||
                         (state == DATA)   || (state == STOP);
    assign report_done = (state == HALT);
    assign last_idx    = verdict ? 4'd5 : 4'd8;

    // Character currently being shifted out; verdict and tnum_sh are frozen
    // for the whole message.
    always_comb begin
        cur_char = 8'h00;
        if (verdict) begin
            case (char_idx)
                4'd0:    cur_char = 8'h50;
                4'd1:    cur_char = 8'h41;
                4'd2:    cur_char = 8'h53;
                4'd3:    cur_char = 8'h53;
                4'd4:    cur_char = 8'h0D;
                4'd5:    cur_char = 8'h0A;
                default: cur_char = 8'h00;
            endcase
        end else begin
            case (char_idx)
                4'd0:    cur_char = 8'h46;
                4'd1:    cur_char = 8'h41;
                4'd2:    cur_char = 8'h49;
                4'd3:    cur_char = 8'h4C;
                4'd4:    cur_char = 8'h20;
                4'd5:    cur_char = hex_ascii(tnum_sh[7:4]);
                4'd6:    cur_char = hex_ascii(tnum_sh[3:0]);
                4'd7:    cur_char = 8'h0D;
                4'd8:    cur_char = 8'h0A;
                default: cur_char = 8'h00;
            endcase
        end
    end

    // Next-state and next-output logic. uart_tx and led are registered so
    // they change exactly on the bit boundaries.
    always_comb begin
        n_state    = state;
        n_verdict  = verdict;
        n_char_idx = char_idx;
        n_bit_idx  = bit_idx;
        n_cnt      = cnt;
        n_tx       = uart_tx;
        n_led      = led;
        case (state)
            IDLE: begin
                if (done_hit)
                    n_state = SETTLE;
            end
            SETTLE: begin
                // pass_sh here is its value at the start of SETTLE, so a
                // PASS_REG write during this cycle does not affect the verdict.
                n_verdict  = (pass_sh == CPU_WIDTH'(1));
                n_led      = {n_verdict, 1'b1};
                n_tx       = 1'b0;
                n_cnt      = DIV_LAST;
                n_char_idx = 4'd0;
                n_bit_idx  = 3'd0;
                n_state    = START;
            end
            START: begin
                if (cnt == 16'd0) begin
                    n_state   = DATA;
                    n_tx      = cur_char[0];
                    n_bit_idx = 3'd0;
                    n_cnt     = DIV_LAST;
                end else begin
                    n_cnt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    n_cnt = DIV_LAST;
                    if (bit_idx == 3'd7) begin
                        n_state = STOP;
                        n_tx    = 1'b1;
                    end else begin
                        n_bit_idx = bit_idx + 3'd1;
                        n_tx      = cur_char[n_bit_idx];
                    end
                end else begin
                    n_cnt = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    if (char_idx == last_idx) begin
                        n_state = HALT;
                        n_tx    = 1'b1;
                    end else begin
                        // next start bit follows with no idle gap
                        n_char_idx = char_idx + 4'd1;
                        n_state    = START;
                        n_tx       = 1'b0;
                        n_cnt      = DIV_LAST;
                    end
                end else begin
                    n_cnt = cnt - 16'd1;
                end
            end
            HALT: begin
                n_tx = 1'b1;
            end
            default: begin
                n_state = IDLE;
                n_tx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            verdict  <= 1'b0;
            char_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            uart_tx  <= 1'b1;
            led      <= 2'b00;
        end else begin
            state    <= n_state;
            verdict  <= n_verdict;
            char_idx <= n_char_idx;
            bit_idx  <= n_bit_idx;
            cnt      <= n_cnt;
            uart_tx  <= n_tx;
            led      <= n_led;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_sh <= '0;
            tnum_sh <= '0;
        end else if (shadow_open && wr_live) begin
            if (wb.reg_wr_addr == PASS_ADDR)
                pass_sh <= wb.reg_wr_data;
            if (wb.reg_wr_addr == TNUM_ADDR)
                tnum_sh <= wb.reg_wr_data;
        end
    end

endmodule

// File: tb/tb_test_status_reporter.sv
// Self-checking bench for test_status_reporter (CLK_DIV = 4).
// Expected UART characters are queued when a test end is triggered and popped
// as the bench-side UART receiver decodes each character from uart_tx.
module tb_test_status_reporter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_tx;
    logic [1:0] led;
    logic       report_busy;
    logic       report_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    logic [7:0] exp_q[$];
    logic [7:0] got, expc;
    bit         ok;
    string      hexs = "0123456789ABCDEF";

    test_status_reporter_if #(.CPU_WIDTH(32)) wb_if ();

    test_status_reporter #(
        .CPU_WIDTH(32),
        .CLK_DIV  (DIV),
        .DONE_REG (26),
        .PASS_REG (27),
        .TNUM_REG (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb_if),
        .uart_tx    (uart_tx),
        .led        (led),
        .report_busy(report_busy),
        .report_done(report_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_msg(input bit pass, input logic [7:0] t);
        if (pass) begin
            exp_q.push_back(8'h50); exp_q.push_back(8'h41);
            exp_q.push_back(8'h53); exp_q.push_back(8'h53);
        end else begin
            exp_q.push_back(8'h46); exp_q.push_back(8'h41);
            exp_q.push_back(8'h49); exp_q.push_back(8'h4C);
            exp_q.push_back(8'h20);
            exp_q.push_back(hexs[t[7:4]]);
            exp_q.push_back(hexs[t[3:0]]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Present one register write for the next clock cycle (leaves enable high).
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_if.reg_wr_en   = 1'b1;
        wb_if.reg_wr_addr = a;
        wb_if.reg_wr_data = d;
    endtask

    task automatic rel();
        @(negedge clk);
        wb_if.reg_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Decode one 8N1 character; ok=0 on timeout or bad start/stop bit.
    task automatic uart_rx(output logic [7:0] b, output bit good);
        bit found;
        found = 1'b0;
        good  = 1'b0;
        b     = '0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) found = 1'b1;
        end
        if (!found) return;
        @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        good = (uart_tx === 1'b1);
    endtask

    task automatic test_reset();
        checks++;
        if ({uart_tx, led, report_busy, report_done} !== 5'b1_00_0_0) begin
            errors++;
            $display("FAIL reset_state: got tx/led/busy/done=%b required 10000",
                     {uart_tx, led, report_busy, report_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        wr(5'd27, 32'd1);
        wr(5'd3, 32'd5);
        wr(5'd26, 32'd1);
        rel();
        push_msg(1'b1, 8'h05);
        checks++;
        if ({led, report_busy} !== 3'b00_1) begin
            errors++;
            $display("FAIL pass_settle: got led/busy=%b required 001", {led, report_busy});
        end
        @(negedge clk);
        t0 = cyc;
        checks++;
        if ({led, uart_tx} !== 3'b11_0) begin
            errors++;
            $display("FAIL pass_led: got led/tx=%b required 110", {led, uart_tx});
        end
        while (exp_q.size() > 0) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL pass_frame: bad frame/timeout, expected char %h", expc);
            end else if (got !== expc) begin
                errors++;
                $display("FAIL pass_char: got %h required %h", got, expc);
            end
        end
        for (int i = 0; i < 50 && !report_done; i++) @(negedge clk);
        checks++;
        if (report_done !== 1'b1 || (cyc - t0) !== 6 * 10 * DIV) begin
            errors++;
            $display("FAIL pass_done_time: got done=%b after %0d cycles required 1 after %0d",
                     report_done, cyc - t0, 6 * 10 * DIV);
        end
        checks++;
        if ({report_busy, uart_tx, led} !== 4'b0_1_11) begin
            errors++;
            $display("FAIL pass_halt: got busy/tx/led=%b required 0111",
                     {report_busy, uart_tx, led});
        end
    endtask

    task automatic test_fail();
        do_reset();
        wr(5'd3, 32'h1C);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        rel();
        push_msg(1'b0, 8'h1C);
        @(negedge clk);
        t0 = cyc;
        checks++;
        if ({led, uart_tx} !== 3'b01_0) begin
            errors++;
            $display("FAIL fail_led: got led/tx=%b required 010", {led, uart_tx});
        end
        while (exp_q.size() > 0) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL fail_frame: bad frame/timeout, expected char %h", expc);
            end else if (got !== expc) begin
                errors++;
                $display("FAIL fail_char: got %h required %h", got, expc);
            end
        end
        for (int i = 0; i < 50 && !report_done; i++) @(negedge clk);
        checks++;
        if (report_done !== 1'b1 || (cyc - t0) !== 9 * 10 * DIV) begin
            errors++;
            $display("FAIL fail_done_time: got done=%b after %0d cycles required 1 after %0d",
                     report_done, cyc - t0, 9 * 10 * DIV);
        end
    endtask

    task automatic test_ignore_value();
        do_reset();
        wr(5'd26, 32'd2);
        rel();
        repeat (4) @(negedge clk);
        checks++;
        if ({led, report_busy, uart_tx} !== 4'b00_0_1) begin
            errors++;
            $display("FAIL ignore_x26_2: got led/busy/tx=%b required 0001",
                     {led, report_busy, uart_tx});
        end
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        rel();
        push_msg(1'b1, 8'h00);
        @(negedge clk);
        checks++;
        if (led !== 2'b11) begin
            errors++;
            $display("FAIL ignore_then_pass_led: got %b required 11", led);
        end
        while (exp_q.size() > 0) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok || got !== expc) begin
                errors++;
                $display("FAIL ignore_then_pass_char: got %h ok=%0d required %h", got, ok, expc);
            end
        end
    endtask

    task automatic test_settle_window();
        // PASS_REG written during SETTLE is too late
        do_reset();
        wr(5'd26, 32'd1);
        wr(5'd27, 32'd1);
        rel();
        push_msg(1'b0, 8'h00);
        checks++;
        if (led !== 2'b01) begin
            errors++;
            $display("FAIL settle_late_led: got %b required 01", led);
        end
        while (exp_q.size() > 0) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok || got !== expc) begin
                errors++;
                $display("FAIL settle_late_char: got %h ok=%0d required %h", got, ok, expc);
            end
        end
        // PASS_REG written back-to-back just before the done write counts
        do_reset();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        rel();
        @(negedge clk);
        checks++;
        if (led !== 2'b11) begin
            errors++;
            $display("FAIL settle_b2b_led: got %b required 11", led);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        rel();
        push_msg(1'b1, 8'h00);
        for (int k = 0; k < 2; k++) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok || got !== expc) begin
                errors++;
                $display("FAIL midrst_char: got %h ok=%0d required %h", got, ok, expc);
            end
        end
        repeat (DIV + 6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({uart_tx, led, report_busy} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL midrst_async: got tx/led/busy=%b required 1000",
                     {uart_tx, led, report_busy});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if ({uart_tx, led, report_busy} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL midrst_no_restart: got tx/led/busy=%b required 1000",
                     {uart_tx, led, report_busy});
        end
        wr(5'd3, 32'h1234_56A5);
        wr(5'd26, 32'd1);
        rel();
        push_msg(1'b0, 8'hA5);
        while (exp_q.size() > 0) begin
            expc = exp_q.pop_front();
            uart_rx(got, ok);
            checks++;
            if (!ok || got !== expc) begin
                errors++;
                $display("FAIL midrst_renew_char: got %h ok=%0d required %h", got, ok, expc);
            end
        end
        for (int i = 0; i < 50 && !report_done; i++) @(negedge clk);
        checks++;
        if ({report_done, led} !== 3'b1_01) begin
            errors++;
            $display("FAIL midrst_renew_done: got done/led=%b required 101", {report_done, led});
        end
    endtask

    task automatic test_halt_sticky();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        wr(5'd3, 32'h77);
        wr(5'd26, 32'd1);
        rel();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({uart_tx, led, report_done, report_busy} !== 5'b1_01_1_0) begin
                errors++;
                $display("FAIL halt_sticky: cycle %0d got tx/led/done/busy=%b required 10110",
                         i, {uart_tx, led, report_done, report_busy});
            end
        end
    endtask

    initial begin
        wb_if.reg_wr_en   = 1'b0;
        wb_if.reg_wr_addr = '0;
        wb_if.reg_wr_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_pass();
        test_fail();
        test_ignore_value();
        test_settle_window();
        test_reset_mid();
        test_halt_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
